camera_spot_finder: RTL and testbench
=====================================

CAMERA_SPOT_FINDER -- requirements
Module: camera_spot_finder

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 SHALL have parameter THRESHOLD, default 8'd200, minimum luma accepted as laser spot.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_1000, first Beta result word address.
REQ-005 SHALL have port clk_50  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port process_frame  input  1  one-cycle pulse arming a search of the next frame.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse marking the start of a camera frame.
REQ-009 SHALL have port line_end  input  1  one-cycle pulse after the last pixel of a line.
REQ-010 SHALL have port pix_valid  input  1  pix_luma is valid this cycle.
REQ-011 SHALL have port pix_luma  input  8  pixel brightness.
REQ-012 SHALL have port beta_mwe  output  1  Beta memory write enable, one word per asserted cycle.
REQ-013 SHALL have port beta_addr  output  32  Beta write address.
REQ-014 SHALL have port beta_din  output  32  Beta write data.
REQ-015 SHALL have port busy  output  1  high from arm until the last result write.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the last result write.

Function
REQ-017 SHALL implement states IDLE, WAIT_FRAME, SCAN, WR_X, WR_Y, WR_S.
REQ-018 IDLE: process_frame -> WAIT_FRAME; busy=1 from the next cycle.
REQ-019 WAIT_FRAME: frame_start -> SCAN; clear x, y, max_luma, spot_x, spot_y, found, short_frame.
REQ-020 SCAN: each pix_valid with x<H_ACTIVE compares pixel; x increments by 1 and saturates at H_ACTIVE.
REQ-021 SCAN: pix_valid with x>=H_ACTIVE ignored for comparison; no wrap.
REQ-022 Capture rule: pix_luma>=THRESHOLD and pix_luma>max_luma (strict) -> max_luma, spot_x=x, spot_y=y, found=1; first pixel wins ties.
REQ-023 line_end in SCAN: x=0, y+1; if y==V_ACTIVE-1 -> WR_X.
REQ-024 pix_valid and line_end in the same cycle: pixel is evaluated at the current x,y before the line advances.
REQ-025 frame_start in SCAN before V_ACTIVE lines: short_frame=1 -> WR_X; the pulse does not start a new scan.
REQ-026 WR_X: beta_mwe=1, beta_addr=BASE_ADDR, beta_din={22'b0, spot_x[9:0]}.
REQ-027 WR_Y: beta_mwe=1, beta_addr=BASE_ADDR+4, beta_din={23'b0, spot_y[8:0]}.
REQ-028 WR_S: beta_mwe=1, beta_addr=BASE_ADDR+8, beta_din={found, short_frame, 22'b0, max_luma}; then IDLE, done=1 for one cycle, busy=0.
REQ-029 Writes SHALL occupy exactly three consecutive cycles, registered; beta_mwe=0, beta_addr=0, beta_din=0 in all other states.
REQ-030 found=0 -> spot_x, spot_y, max_luma written as 0.
REQ-031 process_frame while busy SHALL be ignored; not queued.
REQ-032 Inputs other than process_frame and frame_start SHALL be ignored in IDLE and WAIT_FRAME.
REQ-033 Latency: first result write one cycle after the terminating line_end or frame_start.

Reset
REQ-034 reset low at a rising edge SHALL force IDLE from any state, including mid-scan and mid-write.
REQ-035 On reset, busy=0, done=0, beta_mwe=0, beta_addr=0, beta_din=0, and all counters and result registers=0.
REQ-036 No partial write sequence SHALL resume after reset.

Verification
REQ-037 Arm, 640x480 frame of luma 10 with one pixel 250 at (123,45) -> writes 123, 45, 32'h8000_00FA at 0x1000/0x1004/0x1008, then done.
REQ-038 All pixels below THRESHOLD (199) -> writes 0, 0, 32'h0000_0000; done pulses.
REQ-039 Equal 230 at (10,5) and (300,200) -> x=10, y=5 reported.
REQ-040 frame_start after 100 lines -> status word bit30=1, scan terminated; no new scan without re-arm.
REQ-041 reset low during WR_Y -> beta_mwe=0 next cycle, no WR_S; busy=0, no done.
REQ-042 process_frame during SCAN, and pixels beyond x=639 at luma 255 -> ignored, result unchanged.

Source files
------------

// File: rtl/camera_spot_finder.sv
// -----------------------------------------------------------------------------
// camera_spot_finder
//
// Searches one armed camera frame for the brightest pixel at or above
// THRESHOLD (a laser spot). When the frame ends, three result words are
// written to Beta memory on consecutive cycles:
//   BASE_ADDR+0 : {22'b0, spot_x[9:0]}
//   BASE_ADDR+4 : {23'b0, spot_y[8:0]}
//   BASE_ADDR+8 : {found, short_frame, 22'b0, max_luma}
//
// Ports
//   clk_50        in   sole clock, rising edge
//   reset         in   synchronous, active-low
//   process_frame in   pulse: arm a search of the next frame (ignored while busy)
//   frame_start   in   pulse: start of a camera frame
//   line_end      in   pulse: after the last pixel of a line
//   pix_valid     in   pix_luma valid this cycle
//   pix_luma[7:0] in   pixel brightness
//   beta_mwe      out  Beta write enable (one word per cycle)
//   beta_addr     out  Beta write address
//   beta_din      out  Beta write data
//   busy          out  high from arm until the last result write
//   done          out  one-cycle pulse after the last result write
// -----------------------------------------------------------------------------
module camera_spot_finder #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter logic [7:0]  THRESHOLD = 8'd200,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        process_frame,
  input  logic        frame_start,
  input  logic        line_end,
  input  logic        pix_valid,
  input  logic [7:0]  pix_luma,
  output logic        beta_mwe,
  output logic [31:0] beta_addr,
  output logic [31:0] beta_din,
  output logic        busy,
  output logic        done
);

  // x saturates at H_ACTIVE; at least 10/9 bits so the result slices exist.
  localparam int XW = ($clog2(H_ACTIVE + 1) > 10) ? $clog2(H_ACTIVE + 1) : 10;
  localparam int YW = ($clog2(V_ACTIVE + 1) > 9)  ? $clog2(V_ACTIVE + 1) : 9;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_FRAME = 3'd1;
  localparam logic [2:0] S_SCAN       = 3'd2;
  localparam logic [2:0] S_WR_X       = 3'd3;
  localparam logic [2:0] S_WR_Y       = 3'd4;
  localparam logic [2:0] S_WR_S       = 3'd5;

  logic [2:0]    state,       state_nxt;
  logic [XW-1:0] x,           x_nxt;
  logic [YW-1:0] y,           y_nxt;
  logic [7:0]    max_luma,    max_luma_nxt;
  logic [XW-1:0] spot_x,      spot_x_nxt;
  logic [YW-1:0] spot_y,      spot_y_nxt;
  logic          found,       found_nxt;
  logic          short_frame, short_frame_nxt;

  logic in_line;
  logic last_line;
  logic hit;

  assign in_line   = pix_valid && (x < XW'(H_ACTIVE));
  assign last_line = line_end && (y == YW'(V_ACTIVE - 1));
  // Strict '>' keeps the first pixel on ties.
  assign hit       = in_line && (pix_luma >= THRESHOLD) && (pix_luma > max_luma);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt       = state;
    x_nxt           = x;
    y_nxt           = y;
    max_luma_nxt    = max_luma;
    spot_x_nxt      = spot_x;
    spot_y_nxt      = spot_y;
    found_nxt       = found;
    short_frame_nxt = short_frame;

    case (state)
      S_IDLE: begin
        if (process_frame) state_nxt = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        if (frame_start) begin
          state_nxt       = S_SCAN;
          x_nxt           = '0;
          y_nxt           = '0;
          max_luma_nxt    = '0;
          spot_x_nxt      = '0;
          spot_y_nxt      = '0;
          found_nxt       = 1'b0;
          short_frame_nxt = 1'b0;
        end
      end
      S_SCAN: begin
        // Pixel is judged at the current x,y even if line_end arrives with it.
        if (in_line) x_nxt = x + 1'b1;
        if (hit) begin
          max_luma_nxt = pix_luma;
          spot_x_nxt   = x;
          spot_y_nxt   = y;
          found_nxt    = 1'b1;
        end
        if (line_end) begin
          x_nxt = '0;
          y_nxt = y + 1'b1;
        end
        if (last_line) begin
          state_nxt = S_WR_X;
        end else if (frame_start) begin
          // A new frame before all lines arrived truncates this search.
          short_frame_nxt = 1'b1;
          state_nxt       = S_WR_X;
        end
      end
      S_WR_X:  state_nxt = S_WR_Y;
      S_WR_Y:  state_nxt = S_WR_S;
      S_WR_S:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so the first write lands
  // one cycle after the terminating line_end/frame_start, including a spot
  // captured in that very cycle.
  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_50) begin
    if (!reset) begin
      state       <= S_IDLE;
      x           <= '0;
      y           <= '0;
      max_luma    <= '0;
      spot_x      <= '0;
      spot_y      <= '0;
      found       <= 1'b0;
      short_frame <= 1'b0;
      beta_mwe    <= 1'b0;
      beta_addr   <= '0;
      beta_din    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      max_luma    <= max_luma_nxt;
      spot_x      <= spot_x_nxt;
      spot_y      <= spot_y_nxt;
      found       <= found_nxt;
      short_frame <= short_frame_nxt;
      busy        <= (state_nxt != S_IDLE);
      done        <= (state == S_WR_S);
      beta_mwe    <= 1'b0;
      beta_addr   <= '0;
      beta_din    <= '0;
      case (state_nxt)
        S_WR_X: begin
          beta_mwe  <= 1'b1;
          beta_addr <= BASE_ADDR;
          beta_din  <= {22'b0, spot_x_nxt[9:0]};
        end
        S_WR_Y: begin
          beta_mwe  <= 1'b1;
          beta_addr <= BASE_ADDR + 32'd4;
          beta_din  <= {23'b0, spot_y_nxt[8:0]};
        end
        S_WR_S: begin
          beta_mwe  <= 1'b1;
          beta_addr <= BASE_ADDR + 32'd8;
          beta_din  <= {found_nxt, short_frame_nxt, 22'b0, max_luma_nxt};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_spot_finder.sv
// -----------------------------------------------------------------------------
// tb_camera_spot_finder
// Directed frames on a reduced 20x12 raster with hand-computed result words.
// -----------------------------------------------------------------------------
module tb_camera_spot_finder;

  localparam int          H    = 20;
  localparam int          V    = 12;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk_50 = 1'b0;
  logic        reset = 1'b0;
  logic        process_frame = 1'b0;
  logic        frame_start = 1'b0;
  logic        line_end = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_luma = 8'd0;
  logic        beta_mwe;
  logic [31:0] beta_addr;
  logic [31:0] beta_din;
  logic        busy;
  logic        done;

  camera_spot_finder #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk_50(clk_50), .reset(reset), .process_frame(process_frame),
    .frame_start(frame_start), .line_end(line_end), .pix_valid(pix_valid),
    .pix_luma(pix_luma), .beta_mwe(beta_mwe), .beta_addr(beta_addr),
    .beta_din(beta_din), .busy(busy), .done(done)
  );

  always #10 clk_50 = ~clk_50;

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
    int          c;
  } wr_t;

  wr_t wq[$];
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  done_base = 0;
  int  term_cyc = 0;

  // Write/done monitor, sampled mid-cycle.
  always @(negedge clk_50) begin
    if (beta_mwe) wq.push_back('{beta_addr, beta_din, cyc});
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Frame picture: background plus up to two special pixels (x=-1 disables).
  int base_l = 10;
  int s1x = -1, s1y = -1, s1v = 0;
  int s2x = -1, s2y = -1, s2v = 0;

  function automatic logic [7:0] pix(input int px, input int py);
    if (px == s1x && py == s1y) return 8'(s1v);
    if (px == s2x && py == s2y) return 8'(s2v);
    return 8'(base_l);
  endfunction

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic arm();
    process_frame = 1'b1;
    tick();
    process_frame = 1'b0;
  endtask

  task automatic new_frame_setup();
    wq.delete();
    done_base = done_cnt;
  endtask

  // coinc: line_end rides on the last pixel; extra: two 255 pixels past x=H-1;
  // end_short: frame_start after nlines; arm_mid: process_frame during line 2.
  task automatic run_frame(input int nlines, input bit coinc, input bit extra,
                           input bit end_short, input bit arm_mid);
    // Bright junk while waiting for the frame must be ignored.
    pix_valid = 1'b1; pix_luma = 8'd255; line_end = 1'b1;
    tick();
    pix_valid = 1'b0; line_end = 1'b0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < H; x++) begin
        pix_valid     = 1'b1;
        pix_luma      = pix(x, y);
        process_frame = arm_mid && (y == 2) && (x == 0);
        line_end      = coinc && (x == H - 1);
        if (line_end) term_cyc = cyc;
        tick();
      end
      pix_valid = 1'b0; process_frame = 1'b0; line_end = 1'b0;
      if (extra) begin
        for (int k = 0; k < 2; k++) begin
          pix_valid = 1'b1; pix_luma = 8'd255;
          tick();
        end
        pix_valid = 1'b0;
      end
      if (!coinc) begin
        line_end = 1'b1;
        term_cyc = cyc;
        tick();
        line_end = 1'b0;
      end
      tick();
    end
    if (end_short) begin
      frame_start = 1'b1;
      term_cyc = cyc;
      tick();
      frame_start = 1'b0;
    end
  endtask

  task automatic expect_result(input string tag, input int ex, input int ey,
                               input logic [31:0] es);
    int t = 0;
    while (done_cnt == done_base && t < 200) begin
      tick();
      t++;
    end
    check($sformatf("%s_done", tag), 32'(done_cnt - done_base), 32'd1);
    check($sformatf("%s_nwr", tag), 32'(wq.size()), 32'd3);
    if (wq.size() == 3) begin
      check($sformatf("%s_ax", tag), wq[0].addr, BASE);
      check($sformatf("%s_x", tag),  wq[0].din, 32'(ex));
      check($sformatf("%s_ay", tag), wq[1].addr, BASE + 32'd4);
      check($sformatf("%s_y", tag),  wq[1].din, 32'(ey));
      check($sformatf("%s_as", tag), wq[2].addr, BASE + 32'd8);
      check($sformatf("%s_s", tag),  wq[2].din, es);
      check($sformatf("%s_lat", tag), 32'(wq[0].c), 32'(term_cyc + 1));
      check($sformatf("%s_seq", tag), 32'(wq[2].c - wq[0].c), 32'd2);
      check($sformatf("%s_dcyc", tag), 32'(done_cyc), 32'(wq[2].c + 1));
    end
    check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_y;

    // Reset state.
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mwe",  32'(beta_mwe), 32'd0);
    check("rst_addr", beta_addr, 32'd0);
    check("rst_din",  beta_din, 32'd0);
    reset = 1'b1;
    tick();

    // Single bright spot.
    new_frame_setup();
    base_l = 10; s1x = 7; s1y = 5; s1v = 250; s2x = -1;
    arm();
    check("arm_busy", 32'(busy), 32'd1);
    run_frame(V, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_result("spot", 7, 5, 32'h8000_00FA);

    // Everything just below threshold.
    new_frame_setup();
    base_l = 199; s1x = -1; s2x = -1;
    arm();
    run_frame(V, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_result("dark", 0, 0, 32'h0000_0000);

    // Tie: first occurrence wins.
    new_frame_setup();
    base_l = 10; s1x = 3; s1y = 2; s1v = 230; s2x = 15; s2y = 9; s2v = 230;
    arm();
    run_frame(V, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_result("tie", 3, 2, 32'h8000_00E6);

    // Short frame: new frame_start after 4 lines.
    new_frame_setup();
    base_l = 10; s1x = 1; s1y = 1; s1v = 220; s2x = -1;
    arm();
    run_frame(4, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_result("short", 1, 1, 32'hC000_00DC);

    // No scan without re-arm.
    new_frame_setup();
    run_frame(V, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    check("noarm_nwr",  32'(wq.size()), 32'd0);
    check("noarm_busy", 32'(busy), 32'd0);
    check("noarm_done", 32'(done_cnt - done_base), 32'd0);

    // Arm during scan and out-of-line bright pixels are ignored.
    new_frame_setup();
    base_l = 10; s1x = H - 1; s1y = 3; s1v = 240; s2x = -1;
    arm();
    run_frame(V, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_result("ovr", H - 1, 3, 32'h8000_00F0);
    repeat (4) tick();
    check("ovr_noqueue_busy", 32'(busy), 32'd0);
    check("ovr_noqueue_nwr",  32'(wq.size()), 32'd3);

    // line_end with the last pixel; spot on the very last pixel of the frame.
    new_frame_setup();
    base_l = 10; s1x = H - 1; s1y = V - 1; s1v = 245; s2x = -1;
    arm();
    run_frame(V, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_result("coinc", H - 1, V - 1, 32'h8000_00F5);

    // Reset during WR_Y: sequence aborts, no status word, no done.
    new_frame_setup();
    base_l = 10; s1x = 4; s1y = 4; s1v = 210; s2x = -1;
    arm();
    run_frame(V, 1'b0, 1'b0, 1'b0, 1'b0);
    saw_y = 1'b0;
    for (int t = 0; t < 10 && !saw_y; t++) begin
      @(negedge clk_50);
      if (beta_mwe && beta_addr == BASE + 32'd4) saw_y = 1'b1;
    end
    check("rsty_seen", 32'(saw_y), 32'd1);
    reset = 1'b0;
    @(negedge clk_50);
    check("rsty_mwe",  32'(beta_mwe), 32'd0);
    check("rsty_busy", 32'(busy), 32'd0);
    #1;
    reset = 1'b1;
    repeat (6) tick();
    check("rsty_nwr",  32'(wq.size()), 32'd2);
    check("rsty_done", 32'(done_cnt - done_base), 32'd0);
    check("rsty_idle_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
